// File: rtl/lut_neuron_bank.sv
// ---------------------------------------------------------------------------
// lut_neuron_bank
//
// Bank of NUM_NEURONS runtime-programmable LUT neurons. Each neuron maps its
// IN_BITS input slice to an OUT_BITS result through its own truth table of
// 2**IN_BITS entries. Tables live in registers and are rewritten through the
// cfg_* port, so a layer can be retrained without resynthesis. Results leave
// through a single registered valid/ready stage.
//
// Ports
//   clk         in   clock, all logic on the rising edge
//   rst_n       in   synchronous reset, active-low
//   s_valid     in   input vector valid
//   s_ready     out  bank can accept an input vector
//   s_data      in   neuron n input  = s_data[n*IN_BITS +: IN_BITS]
//   m_valid     out  output vector valid
//   m_ready     in   downstream accepts the output
//   m_data      out  neuron n output = m_data[n*OUT_BITS +: OUT_BITS]
//   cfg_we      in   table write strobe, one entry per cycle
//   cfg_neuron  in   target neuron index
//   cfg_addr    in   target table entry
//   cfg_data    in   entry value
//   cfg_err     out  sticky: a write addressed a neuron that does not exist
//   out_count   out  number of output handshakes, wraps at 16 bits
// ---------------------------------------------------------------------------
module lut_neuron_bank #(
    parameter int IN_BITS     = 5,
    parameter int OUT_BITS    = 1,
    parameter int NUM_NEURONS = 4,
    parameter int NIDX_W      = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic [NUM_NEURONS*IN_BITS-1:0]  s_data,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic [NUM_NEURONS*OUT_BITS-1:0] m_data,
    input  logic                            cfg_we,
    input  logic [NIDX_W-1:0]               cfg_neuron,
    input  logic [IN_BITS-1:0]              cfg_addr,
    input  logic [OUT_BITS-1:0]             cfg_data,
    output logic                            cfg_err,
    output logic [15:0]                     out_count
);

    localparam int DEPTH = 2 ** IN_BITS;

    logic [OUT_BITS-1:0]             tbl [NUM_NEURONS][DEPTH];
    logic [NUM_NEURONS*OUT_BITS-1:0] lookup;
    logic [NUM_NEURONS-1:0]          cfg_hit;
    logic                            accept;

    // The output register is the only buffer, so a new vector may enter
    // whenever it is empty or is being drained on this same edge.
    assign s_ready = !m_valid || m_ready;
    assign accept  = s_valid && s_ready;

    // NOTE: every variable driven in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        lookup = '0;
        for (int n = 0; n < NUM_NEURONS; n++) begin
            lookup[n*OUT_BITS +: OUT_BITS] = tbl[n][s_data[n*IN_BITS +: IN_BITS]];
        end
    end

    // One-hot decode of the write target. Comparing against each neuron
    // index, rather than indexing the table with cfg_neuron directly, keeps
    // an out-of-range index from aliasing onto a real neuron.
    always_comb begin
        cfg_hit = '0;
        for (int n = 0; n < NUM_NEURONS; n++) begin
            cfg_hit[n] = cfg_we && (cfg_neuron == NIDX_W'(n));
        end
    end

    // Truth tables. The lookup above reads the current register contents,
    // so a write and an accept on the same edge see the old entry.
    // NOTE: the tables are deliberately cleared on reset so a freshly reset
    // bank produces all-zero results; this forbids mapping them onto RAM,
    // which is acceptable at this table size.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int n = 0; n < NUM_NEURONS; n++) begin
                for (int a = 0; a < DEPTH; a++) begin
                    tbl[n][a] <= '0;
                end
            end
        end else begin
            for (int n = 0; n < NUM_NEURONS; n++) begin
                if (cfg_hit[n]) begin
                    tbl[n][cfg_addr] <= cfg_data;
                end
            end
        end
    end

    // Registered output stage. A held vector keeps m_data untouched; after
    // a drain with no new accept only m_valid falls.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
        end else if (accept) begin
            m_valid <= 1'b1;
            m_data  <= lookup;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

    // Sticky error for writes to a neuron that does not exist, and the
    // free-running handshake counter (wraps naturally at 16 bits).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cfg_err   <= 1'b0;
            out_count <= '0;
        end else begin
            if (cfg_we && !(|cfg_hit)) begin
                cfg_err <= 1'b1;
            end
            if (m_valid && m_ready) begin
                out_count <= out_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_lut_neuron_bank.sv
// ---------------------------------------------------------------------------
// tb_lut_neuron_bank
//
// Directed testbench for lut_neuron_bank. The driver pushes the hand-computed
// result of every accepted vector into a queue; a monitor pops and compares
// on each output handshake. NIDX_W is widened to 3 so a write to a neuron
// index beyond the bank can be issued.
// ---------------------------------------------------------------------------
module tb_lut_neuron_bank;

    localparam int IN_BITS     = 5;
    localparam int OUT_BITS    = 1;
    localparam int NUM_NEURONS = 4;
    localparam int NIDX_W      = 3;
    localparam int SW          = NUM_NEURONS * IN_BITS;
    localparam int MW          = NUM_NEURONS * OUT_BITS;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              s_valid;
    logic              s_ready;
    logic [SW-1:0]     s_data;
    logic              m_valid;
    logic              m_ready;
    logic [MW-1:0]     m_data;
    logic              cfg_we;
    logic [NIDX_W-1:0] cfg_neuron;
    logic [IN_BITS-1:0] cfg_addr;
    logic [OUT_BITS-1:0] cfg_data;
    logic              cfg_err;
    logic [15:0]       out_count;

    lut_neuron_bank #(
        .IN_BITS    (IN_BITS),
        .OUT_BITS   (OUT_BITS),
        .NUM_NEURONS(NUM_NEURONS),
        .NIDX_W     (NIDX_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .cfg_we    (cfg_we),
        .cfg_neuron(cfg_neuron),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cfg_err   (cfg_err),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [MW-1:0] exp_q [$];
    logic [15:0]   n_sent;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one comparison per output handshake, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 32'(m_data), 32'hDEAD);
            end else begin
                check("m_data", 32'(m_data), 32'(exp_q.pop_front()));
            end
        end
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic send(input logic [SW-1:0] data, input logic [MW-1:0] exp);
        bit done = 0;
        s_valid = 1'b1;
        s_data  = data;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (s_ready) begin
                exp_q.push_back(exp);
                n_sent = n_sent + 16'd1;
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        if (!done) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic cfg_write(input int neuron, input int addr, input logic [OUT_BITS-1:0] data);
        cfg_we     = 1'b1;
        cfg_neuron = NIDX_W'(neuron);
        cfg_addr   = IN_BITS'(addr);
        cfg_data   = data;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic drain();
        bit done = 0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (!m_valid) done = 1;
        end
        @(posedge clk);
        #1;
        if (!done) check("drain_timeout", 32'd0, 32'd1);
    endtask

    logic [31:0] pattern;

    initial begin
        rst_n      = 1'b0;
        s_valid    = 1'b0;
        s_data     = '0;
        m_ready    = 1'b1;
        cfg_we     = 1'b0;
        cfg_neuron = '0;
        cfg_addr   = '0;
        cfg_data   = '0;
        n_sent     = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 1. Reset state
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd1);
        check("rst_cfg_err", 32'(cfg_err), 32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);

        // 2. Program neuron 0 and look up a few entries
        pattern = 32'hEAFAFAFE;
        for (int k = 0; k < 32; k++) cfg_write(0, k, pattern[k]);
        send(20'h00004, 4'b0001);                       // entry 4  -> 1
        check("latency_m_valid", 32'(m_valid), 32'd1);
        send(20'h0001C, 4'b0000);                       // entry 28 -> 0
        send(20'h00000, 4'b0000);                       // entry 0  -> 0
        send({5'd31, 5'd7, 5'd3, 5'd1}, 4'b0001);       // entry 1 -> 1, others empty
        drain();
        check("count_after_t2", 32'(out_count), 32'(n_sent));

        // 3. Backpressure: one vector held, next vector waits
        m_ready = 1'b0;
        send(20'h00004, 4'b0001);
        s_valid = 1'b1;
        s_data  = 20'h0001C;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_s_ready", 32'(s_ready), 32'd0);
            check("hold_m_valid", 32'(m_valid), 32'd1);
            check("hold_m_data", 32'(m_data), 32'b0001);
        end
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        send(20'h0001C, 4'b0000);
        send(20'h00001, 4'b0001);
        send(20'h00000, 4'b0000);
        drain();
        check("count_after_t3", 32'(out_count), 32'(n_sent));

        // 4. Write and accept on the same edge: old entry used
        cfg_we     = 1'b1;
        cfg_neuron = 3'd1;
        cfg_addr   = 5'd3;
        cfg_data   = 1'b1;
        send(20'h00060, 4'b0000);
        cfg_we = 1'b0;
        send(20'h00060, 4'b0010);
        drain();

        // 5. Out-of-range writes: sticky error, tables untouched
        cfg_write(4, 0, 1'b1);
        check("cfg_err_set", 32'(cfg_err), 32'd1);
        cfg_write(5, 2, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("cfg_err_sticky", 32'(cfg_err), 32'd1);
        send(20'h00064, 4'b0011);                       // n0[4]=1, n1[3]=1
        send(20'h00040, 4'b0000);                       // n0[0]=0, n1[2]=0
        drain();

        // Reset while a vector is held
        m_ready = 1'b0;
        send(20'h00004, 4'b0001);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        n_sent = '0;
        check("midrst_m_valid", 32'(m_valid), 32'd0);
        check("midrst_m_data", 32'(m_data), 32'd0);
        check("midrst_cfg_err", 32'(cfg_err), 32'd0);
        check("midrst_out_count", 32'(out_count), 32'd0);
        m_ready = 1'b1;
        send(20'h00064, 4'b0000);                       // tables cleared
        drain();

        // 6. Counter wrap
        for (int i = 1; i < 65535; i++) send(20'h00000, 4'b0000);
        drain();
        check("count_ffff", 32'(out_count), 32'h0000FFFF);
        send(20'h00000, 4'b0000);
        drain();
        check("count_wrap", 32'(out_count), 32'h00000000);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
